// File: rtl/road_row_gen.sv
// Road row generator: an LFSR-driven straight/left/right FSM that produces one road row (left/right edges) per accepted tick.
// Optional build macro ROAD_NARROW_EN narrows the road by one unit every 64 rows, down to a half-width floor of 20.
module road_row_gen #(
  parameter int unsigned XCENTER = 464,
  parameter int unsigned HALF_W  = 50,
  parameter int unsigned X_MIN   = 154,
  parameter int unsigned X_MAX   = 773
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        tick,
  input  logic        row_ready,
  output logic        row_valid,
  output logic [9:0]  left_edge,
  output logic [9:0]  right_edge,
  output logic [1:0]  curve_dir,
  output logic        overrun,
  output logic [15:0] row_count
);

  typedef enum logic [1:0] {
    STRAIGHT = 2'b00,
    LEFT     = 2'b01,
    RIGHT    = 2'b10
  } state_t;

  localparam logic [9:0]  XC10    = 10'(XCENTER);
  localparam logic [9:0]  HW10    = 10'(HALF_W);
  localparam logic [9:0]  XMIN10  = 10'(X_MIN);
  localparam logic [9:0]  XMAX10  = 10'(X_MAX);
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam logic [5:0]  SEG_RST = 6'd32;
`ifdef ROAD_NARROW_EN
  localparam logic [9:0]  HALF_MIN = 10'd20;
`endif

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  seg_q, seg_d;
  logic [9:0]  centre_q, centre_d;
  logic [9:0]  half_q, half_d;
  logic [9:0]  left_q, left_d;
  logic [9:0]  right_q, right_d;
  logic        valid_q, valid_d;
  logic        over_q, over_d;
  logic [15:0] count_q, count_d;

  logic        gen;
  logic        fb;
  logic [15:0] count_inc;
  logic [9:0]  half_gen;
  logic [9:0]  centre_step;
  logic [9:0]  step_left;
  logic [9:0]  step_right;
  logic        blocked;
  logic [5:0]  seg_len;
  state_t      pick;

  assign fb        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign gen       = tick && (!valid_q || row_ready);
  assign count_inc = count_q + 16'd1;
  assign seg_len   = 6'd16 + {1'b0, lfsr_q[4:0]};

  always_comb begin
    half_gen = half_q;
`ifdef ROAD_NARROW_EN
    if (count_inc[5:0] == 6'd0 && half_q > HALF_MIN) half_gen = half_q - 10'd1;
`endif
  end

  always_comb begin
    case (state_q)
      LEFT:    centre_step = centre_q - 10'd1;
      RIGHT:   centre_step = centre_q + 10'd1;
      default: centre_step = centre_q;
    endcase
    step_left  = centre_step - half_gen;
    step_right = centre_step + half_gen;
    blocked    = (step_left < XMIN10) || (step_right > XMAX10);
    case (lfsr_q[6:5])
      2'b10:   pick = LEFT;
      2'b11:   pick = RIGHT;
      default: pick = STRAIGHT;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    seg_d    = seg_q;
    centre_d = centre_q;
    half_d   = half_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = valid_q;
    over_d   = over_q;
    count_d  = count_q;
    if (restart) begin
      state_d  = STRAIGHT;
      seg_d    = SEG_RST;
      centre_d = XC10;
      half_d   = HW10;
      left_d   = XC10 - HW10;
      right_d  = XC10 + HW10;
      valid_d  = 1'b0;
      over_d   = 1'b0;
      count_d  = '0;
    end else begin
      if (tick && valid_q && !row_ready) over_d = 1'b1;
      if (gen) begin
        lfsr_d  = {lfsr_q[14:0], fb};
        count_d = count_inc;
        half_d  = half_gen;
        valid_d = 1'b1;
        // A blocked step overrides the segment counter: hold, go straight, fresh length.
        if (blocked) begin
          state_d = STRAIGHT;
          seg_d   = seg_len;
        end else begin
          centre_d = centre_step;
          if (seg_q == 6'd0) begin
            state_d = pick;
            seg_d   = seg_len;
          end else begin
            seg_d = seg_q - 6'd1;
          end
        end
        left_d  = centre_d - half_gen;
        right_d = centre_d + half_gen;
      end else if (row_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= STRAIGHT;
      lfsr_q   <= SEED;
      seg_q    <= SEG_RST;
      centre_q <= XC10;
      half_q   <= HW10;
      left_q   <= XC10 - HW10;
      right_q  <= XC10 + HW10;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seg_q    <= seg_d;
      centre_q <= centre_d;
      half_q   <= half_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
      over_q   <= over_d;
      count_q  <= count_d;
    end
  end

  assign row_valid  = valid_q;
  assign left_edge  = left_q;
  assign right_edge = right_q;
  assign curve_dir  = state_q;
  assign overrun    = over_q;
  assign row_count  = count_q;

endmodule
